sync_fifo: RTL and testbench

Single-clock, parametrised FIFO for SD-controller datapaths that sit entirely inside one clock domain, such as the command/response staging and DMA burst buffering. It generalises the team's dual-clock FIFO in three ways:
- it has a selectable read mode: standard 1-cycle latency or first-word-fall-through;
- it reports an occupancy count and programmable almost-full/almost-empty flags;
- it raises overflow/underflow error pulses.

It uses no gray-code synchronisers; all state lives in the single clock domain.

---
 rtl/sync_fifo.sv | 104 ++++++++++
 tb/tb_sync_fifo.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read mode.
// It provides an occupancy count, programmable almost flags and overflow/underflow pulses.
module sync_fifo #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 6,
   parameter int FWFT       = 0,
   parameter int AF_LEVEL   = (1 << DEPTH_LOG2) - 4,
   parameter int AE_LEVEL   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      din,
   output logic                  full,
   output logic                  almost_full,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      dout,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;
   localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
   localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         count_q, count_d;
   logic                  full_q, empty_q, almost_full_q, almost_empty_q;
   logic                  overflow_q, underflow_q;
   logic                  wr_acc, rd_acc;
   logic [DEPTH_LOG2-1:0] rd_idx;

   // Acceptance uses the registered flags only, so a same-cycle pop never frees a slot
   // for a push, and a same-cycle push never feeds a pop.
   assign wr_acc = wr_en & ~full_q;
   assign rd_acc = rd_en & ~empty_q;
   assign rd_idx = rd_ptr_q[DEPTH_LOG2-1:0];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      // Pointers wrap modulo 2*DEPTH, so their difference is the exact occupancy 0..DEPTH.
      count_d = wr_ptr_d - rd_ptr_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         full_q         <= 1'b0;
         empty_q        <= 1'b1;
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         full_q         <= (count_d == DEPTH_C);
         empty_q        <= (count_d == '0);
         almost_full_q  <= (count_d >= AF_C);
         almost_empty_q <= (count_d <= AE_C);
         overflow_q     <= wr_en & full_q;
         underflow_q    <= rd_en & empty_q;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc && !rst) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign dout = mem_q[rd_idx];
      end else begin : g_std
         logic [WIDTH-1:0] dout_q;
         always_ff @(posedge clk) begin
            if (rst)         dout_q <= '0;
            else if (rd_acc) dout_q <= mem_q[rd_idx];
         end
         assign dout = dout_q;
      end
   endgenerate

   assign count        = count_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = almost_full_q;
   assign almost_empty = almost_empty_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: one standard-mode and one FWFT instance share the same stimulus.
// A queue model is checked every cycle, alongside directed literal expectations.
module tb_sync_fifo;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst, wr_en, rd_en;
   logic [31:0] din;

   logic        s_full, s_af, s_empty, s_ae, s_ov, s_un;
   logic [31:0] s_dout;
   logic [6:0]  s_count;
   logic        f_full, f_af, f_empty, f_ae, f_ov, f_un;
   logic [31:0] f_dout;
   logic [6:0]  f_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sync_fifo #(.WIDTH(32), .DEPTH_LOG2(6), .FWFT(0), .AF_LEVEL(60), .AE_LEVEL(4)) u_std (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(s_full), .almost_full(s_af),
      .rd_en(rd_en), .dout(s_dout), .empty(s_empty), .almost_empty(s_ae), .count(s_count),
      .overflow(s_ov), .underflow(s_un));

   sync_fifo #(.WIDTH(32), .DEPTH_LOG2(6), .FWFT(1), .AF_LEVEL(60), .AE_LEVEL(4)) u_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(f_full), .almost_full(f_af),
      .rd_en(rd_en), .dout(f_dout), .empty(f_empty), .almost_empty(f_ae), .count(f_count),
      .overflow(f_ov), .underflow(f_un));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: the FIFO is a queue; flags and pulses follow from its size at each edge.
   logic [31:0] q[$];
   logic [31:0] m_std_dout = '0;
   logic        m_ov = 1'b0, m_un = 1'b0;
   bit          model_valid = 1'b0;

   always @(posedge clk) begin
      automatic bit was_full  = (q.size() == DEPTH);
      automatic bit was_empty = (q.size() == 0);
      if (rst) begin
         q.delete();
         m_std_dout  <= '0;
         m_ov        <= 1'b0;
         m_un        <= 1'b0;
         model_valid <= 1'b1;
      end else begin
         m_ov <= wr_en && was_full;
         m_un <= rd_en && was_empty;
         if (rd_en && !was_empty) begin
            m_std_dout <= q[0];
            q.pop_front();
         end
         if (wr_en && !was_full) q.push_back(din);
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         chk("s_count", 32'(s_count), 32'(q.size()));
         chk("f_count", 32'(f_count), 32'(q.size()));
         chk("s_empty", 32'(s_empty), 32'(q.size() == 0));
         chk("f_empty", 32'(f_empty), 32'(q.size() == 0));
         chk("s_full",  32'(s_full),  32'(q.size() == DEPTH));
         chk("f_full",  32'(f_full),  32'(q.size() == DEPTH));
         chk("s_af",    32'(s_af),    32'(q.size() >= 60));
         chk("f_af",    32'(f_af),    32'(q.size() >= 60));
         chk("s_ae",    32'(s_ae),    32'(q.size() <= 4));
         chk("f_ae",    32'(f_ae),    32'(q.size() <= 4));
         chk("s_ov",    32'(s_ov),    32'(m_ov));
         chk("f_ov",    32'(f_ov),    32'(m_ov));
         chk("s_un",    32'(s_un),    32'(m_un));
         chk("f_un",    32'(f_un),    32'(m_un));
         chk("s_dout",  s_dout,       m_std_dout);
         if (q.size() != 0) chk("f_dout", f_dout, q[0]);
      end
   end

   // Drive one edge's inputs, then return at the following negedge.
   task automatic cyc(input bit w, input bit r, input logic [31:0] d, input bit rs);
      wr_en = w; rd_en = r; din = d; rst = rs;
      @(negedge clk);
   endtask

   initial begin
      wr_en = 1'b0; rd_en = 1'b0; din = '0; rst = 1'b1;
      @(negedge clk);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
      chk("rst_count", 32'(s_count), 0);
      chk("rst_empty", 32'(s_empty), 1);
      chk("rst_full",  32'(f_full),  0);
      chk("rst_ae",    32'(s_ae),    1);
      chk("rst_af",    32'(f_af),    0);
      chk("rst_dout",  s_dout,       0);

      // Fill to DEPTH; almost_empty drops once count reaches 5.
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1, 0, 32'(i), 0);
         chk("fill_count", 32'(s_count), 32'(i + 1));
         chk("fill_ae",    32'(s_ae),    32'(i + 1 <= 4));
      end
      chk("fill_full", 32'(s_full), 1);
      chk("fill_af",   32'(f_af),   1);
      cyc(1, 0, 32'hDEAD, 0);
      chk("ovf_pulse", 32'(s_ov),    1);
      chk("ovf_count", 32'(s_count), 64);
      cyc(0, 0, 0, 0);
      chk("ovf_clear", 32'(f_ov), 0);

      // Drain: FWFT shows the head before popping, standard shows it after.
      for (int i = 0; i < DEPTH; i++) begin
         chk("fwft_head", f_dout, 32'(i));
         cyc(0, 1, 0, 0);
         chk("drain_dout", s_dout, 32'(i));
      end
      cyc(0, 1, 0, 0);
      chk("drain_un",   32'(s_un), 1);
      chk("drain_hold", s_dout,    63);

      // Standard mode with 0xA, 0xB.
      cyc(1, 0, 32'hA, 0);
      cyc(1, 0, 32'hB, 0);
      cyc(0, 1, 0, 0);
      chk("std_A", s_dout, 32'hA);
      cyc(0, 1, 0, 0);
      chk("std_B", s_dout, 32'hB);
      cyc(0, 1, 0, 0);
      chk("std_un",   32'(s_un), 1);
      chk("std_hold", s_dout,    32'hB);

      // FWFT visibility without rd_en.
      cyc(1, 0, 32'h5A5A, 0);
      chk("fw_empty", 32'(f_empty), 0);
      chk("fw_dout",  f_dout,       32'h5A5A);
      cyc(0, 1, 0, 0);
      chk("fw_pop_empty", 32'(f_empty), 1);
      chk("fw_pop_count", 32'(f_count), 0);

      // Fill to 32, then 200 cycles of simultaneous push and pop across pointer wraps.
      for (int i = 0; i < 32; i++) cyc(1, 0, 32'(1000 + i), 0);
      for (int k = 0; k < 200; k++) begin
         cyc(1, 1, 32'(2000 + k), 0);
         chk("stream_count", 32'(s_count), 32);
         chk("stream_dout",  s_dout, (k < 32) ? 32'(1000 + k) : 32'(2000 + k - 32));
      end
      for (int i = 0; i < 32; i++) cyc(0, 1, 0, 0);
      chk("stream_last", s_dout, 32'(2000 + 199));

      // Boundaries: push+pop when empty, then when full.
      cyc(1, 1, 32'h77, 0);
      chk("bnd_e_count", 32'(s_count), 1);
      chk("bnd_e_un",    32'(s_un),    1);
      for (int i = 0; i < DEPTH - 1; i++) cyc(1, 0, 32'(3000 + i), 0);
      chk("bnd_full", 32'(f_full), 1);
      cyc(1, 1, 32'h88, 0);
      chk("bnd_f_count", 32'(s_count), 63);
      chk("bnd_f_ov",    32'(f_ov),    1);
      chk("bnd_f_dout",  s_dout,       32'h77);

      // Reset mid-operation with count=20 and a same-cycle write.
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 20; i++) cyc(1, 0, 32'(4000 + i), 0);
      chk("pre_rst_count", 32'(s_count), 20);
      cyc(1, 0, 32'hBAD, 1);
      chk("rst_mid_count", 32'(f_count), 0);
      chk("rst_mid_empty", 32'(s_empty), 1);
      chk("rst_mid_full",  32'(s_full),  0);
      chk("rst_mid_ov",    32'(s_ov),    0);
      chk("rst_mid_dout",  s_dout,       0);
      cyc(0, 0, 0, 0);
      chk("rst_discard", 32'(s_count), 0);
      cyc(1, 0, 32'h33, 0);
      chk("post_rst_fw", f_dout, 32'h33);
      cyc(0, 1, 0, 0);
      chk("post_rst_std", s_dout, 32'h33);
      cyc(0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
